// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC sample SPI master: FSM states, frame
// geometry, byte1 field positions and the frame builder.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BYTE_BITS  = 8;
    localparam int unsigned SAMPLE_W   = 10;
    localparam int unsigned CHANNEL_W  = 4;
    localparam int unsigned DIV_W      = 8;
    localparam int unsigned BIT_CNT_W  = 3;

    // byte1 layout: {channel, 2'b00, sample[9:8]}
    localparam int unsigned B1_CH_MSB   = 7;
    localparam int unsigned B1_CH_LSB   = 4;
    localparam int unsigned B1_SMSB_MSB = 1;
    localparam int unsigned B1_SMSB_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_BYTE0,
        ST_GAP,
        ST_BYTE1,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    // byte0 sits in the MSBs so the frame shifts out byte0 first, MSB first
    typedef struct packed {
        logic [BYTE_BITS-1:0] byte0;
        logic [BYTE_BITS-1:0] byte1;
    } frame_t;

    function automatic frame_t build_frame(input logic [SAMPLE_W-1:0]  sample,
                                           input logic [CHANNEL_W-1:0] channel);
        frame_t f;
        f.byte0 = sample[BYTE_BITS-1:0];
        f.byte1 = '0;
        f.byte1[B1_CH_MSB:B1_CH_LSB]     = channel;
        f.byte1[B1_SMSB_MSB:B1_SMSB_LSB] = sample[SAMPLE_W-1:BYTE_BITS];
        return f;
    endfunction

endpackage

// File: rtl/adc_sample_spi_master_if.sv
// Handshake and SPI pin bundle for adc_sample_spi_master.
//   start/sample/channel : frame request and payload (into master)
//   busy/done/rx_data    : status and captured MISO word (from master)
//   spi_ss/sck/mosi/miso : SPI pins, ss active-low
interface adc_sample_spi_master_if;
    import adc_spi_pkg::*;

    logic                  start;
    logic [SAMPLE_W-1:0]   sample;
    logic [CHANNEL_W-1:0]  channel;
    logic                  busy;
    logic                  done;
    logic                  spi_ss;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [FRAME_BITS-1:0] rx_data;

    modport master (
        input  start, sample, channel, spi_miso,
        output busy, done, spi_ss, spi_sck, spi_mosi, rx_data
    );

    modport slave (
        output start, sample, channel, spi_miso,
        input  busy, done, spi_ss, spi_sck, spi_mosi, rx_data
    );
endinterface

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV-cycle half-period counter producing a registered
// SCK level plus combinational rise/fall strobes (active on the clk edge
// where SCK toggles). Held low and cleared while en is low.
//   clk, rst : clock, async active-high reset
//   en       : run enable (byte-shifting states only)
//   sck      : SCK level, starts low on enable
//   rise_c   : this edge drives SCK 0->1
//   fall_c   : this edge drives SCK 1->0
module spi_sck_gen
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic rise_c,
    output logic fall_c
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             half_end_c;

    assign half_end_c = en && (div_cnt == DIV_LAST);
    assign rise_c     = half_end_c && !sck;
    assign fall_c     = half_end_c && sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (half_end_c) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/adc_sample_spi_master.sv
// SPI mode-0 master sending one 2-byte ADC sample frame per accepted start:
// byte0 = sample[7:0], byte1 = {channel, 2'b00, sample[9:8]}, MSB first.
// Ports:
//   clk, rst : clock (rising edge), async active-high reset
//   bus      : adc_sample_spi_master_if.master (start/sample/channel in,
//              busy/done/rx_data out, SPI pins)
// Parameter CLK_DIV (2..255): clk cycles per SCK half-period.
// Macro ADC_SPI_MISO_CAPTURE_EN: when defined, MISO is sampled on each SCK
// rise and rx_data = {byte1, byte0} updates in the done cycle; otherwise
// rx_data is constant zero and MISO is ignored.
module adc_sample_spi_master
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    adc_sample_spi_master_if.master  bus
);

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BYTE_BITS - 1);

    state_t                state;
    logic [DIV_W-1:0]      phase_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic                  ss;
    logic                  mosi;
    logic                  busy;
    logic                  done;
    logic [FRAME_BITS-1:0] rx_word;

    logic sck;
    logic sck_en_c;
    logic sck_rise_c;
    logic sck_fall_c;
    logic phase_last_c;

    assign sck_en_c     = (state == ST_BYTE0) || (state == ST_BYTE1);
    assign phase_last_c = (phase_cnt == DIV_LAST);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (sck_en_c),
        .sck    (sck),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    // Frame sequencer; MOSI only moves on edges that leave SCK low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state     <= ST_SETUP;
                        tx_shift  <= build_frame(bus.sample, bus.channel);
                        phase_cnt <= '0;
                        ss        <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_SETUP, ST_GAP: begin
                    if (phase_last_c) begin
                        state     <= (state == ST_SETUP) ? ST_BYTE0 : ST_BYTE1;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        mosi      <= tx_shift[FRAME_BITS-1];
                        tx_shift  <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        phase_cnt <= phase_cnt + DIV_W'(1);
                    end
                end
                ST_BYTE0, ST_BYTE1: begin
                    if (sck_fall_c) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= (state == ST_BYTE0) ? ST_GAP : ST_HOLD;
                            mosi  <= 1'b0;
                        end else begin
                            mosi     <= tx_shift[FRAME_BITS-1];
                            tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_last_c) begin
                        state     <= ST_RECOVER;
                        phase_cnt <= '0;
                        ss        <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + DIV_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (phase_last_c) begin
                        state     <= ST_IDLE;
                        phase_cnt <= '0;
                        busy      <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + DIV_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ADC_SPI_MISO_CAPTURE_EN
    logic [FRAME_BITS-1:0] rx_shift;

    // MISO shift on SCK rise; byte0 arrives first so swap halves on publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift <= '0;
            rx_word  <= '0;
        end else begin
            if (sck_rise_c) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], bus.spi_miso};
            end
            if ((state == ST_HOLD) && phase_last_c) begin
                rx_word <= {rx_shift[BYTE_BITS-1:0], rx_shift[FRAME_BITS-1:BYTE_BITS]};
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = bus.spi_miso ^ sck_rise_c;
    assign rx_word     = '0;
`endif

    assign bus.spi_ss   = ss;
    assign bus.spi_sck  = sck;
    assign bus.spi_mosi = mosi;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rx_data  = rx_word;

endmodule

// File: tb/tb_adc_sample_spi_master.sv
// Bench for adc_sample_spi_master: two instances (CLK_DIV=4 and CLK_DIV=2)
// checked against a frame-level model of bytes, pin timing and rx word.
module tb_adc_sample_spi_master;

    logic        clk;
    logic        rst;
    logic        start4;
    logic        start2;
    logic [9:0]  smp_in;
    logic [3:0]  ch_in;
    logic        miso;
    int          total;
    int          bad;
    bit          sel;

    logic        m_ss, m_sck, m_mosi, m_busy, m_done;
    logic [15:0] m_rx;

    adc_sample_spi_master_if bus4();
    adc_sample_spi_master_if bus2();

    adc_sample_spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    adc_sample_spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus4.start    = start4;
    assign bus2.start    = start2;
    assign bus4.sample   = smp_in;
    assign bus2.sample   = smp_in;
    assign bus4.channel  = ch_in;
    assign bus2.channel  = ch_in;
    assign bus4.spi_miso = miso;
    assign bus2.spi_miso = miso;

    always_comb begin
        m_ss   = sel ? bus2.spi_ss   : bus4.spi_ss;
        m_sck  = sel ? bus2.spi_sck  : bus4.spi_sck;
        m_mosi = sel ? bus2.spi_mosi : bus4.spi_mosi;
        m_busy = sel ? bus2.busy     : bus4.busy;
        m_done = sel ? bus2.done     : bus4.done;
        m_rx   = sel ? bus2.rx_data  : bus4.rx_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [4:0] pins;
        rst = 1'b0; start4 = 1'b0; start2 = 1'b0; miso = 1'b0;
        smp_in = '0; ch_in = '0; sel = 1'b0;
        #2 rst = 1'b1;
        #1;
        pins = {bus4.spi_ss, bus4.spi_sck, bus4.spi_mosi, bus4.busy, bus4.done};
        total++; if (pins !== 5'b10000) begin bad++; $display("FAIL reset_pins_div4 got %b want 10000", pins); end
        total++; if (bus4.rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx_div4 got %h want 0000", bus4.rx_data); end
        pins = {bus2.spi_ss, bus2.spi_sck, bus2.spi_mosi, bus2.busy, bus2.done};
        total++; if (pins !== 5'b10000) begin bad++; $display("FAIL reset_pins_div2 got %b want 10000", pins); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pins = {bus4.spi_ss, bus4.spi_sck, bus4.spi_mosi, bus4.busy, bus4.done};
        total++; if (pins !== 5'b10000) begin bad++; $display("FAIL idle_after_reset got %b want 10000", pins); end
    endtask

    // One frame with slave responses; k counts cycles after the accepting edge
    task automatic test_frame(input string name, input bit use2, input int d,
                              input logic [9:0] smp, input logic [3:0] ch,
                              input logic [7:0] sb0, input logic [7:0] sb1, input bit chg);
        logic [7:0]  exp_b0, exp_b1;
        logic [15:0] exp_rx, got, slave_word, rx_at_done;
        logic        prev_sck, prev_mosi, exp_busy;
        int ss_first, ss_last, ss_cnt, done_cnt, done_at, nrise, first_rise;
        int last_rise, per_err, viol, busy_err;
        exp_b0 = 8'(int'(smp) % 256);
        exp_b1 = 8'(int'(ch) * 16 + int'(smp) / 256);
`ifdef ADC_SPI_MISO_CAPTURE_EN
        exp_rx = {sb1, sb0};
`else
        exp_rx = 16'h0000;
`endif
        slave_word = {sb0, sb1};
        got = '0; rx_at_done = 16'hxxxx;
        ss_first = 0; ss_last = 0; ss_cnt = 0; done_cnt = 0; done_at = 0;
        nrise = 0; first_rise = 0; last_rise = 0; per_err = 0; viol = 0; busy_err = 0;
        prev_sck = 1'b0; prev_mosi = 1'b0;
        sel = use2;
        @(negedge clk);
        smp_in = smp; ch_in = ch;
        if (use2) start2 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; start2 = 1'b0;
        if (chg) begin smp_in = '0; ch_in = '0; end
        for (int k = 1; k <= 36 * d + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (m_ss === 1'b0) begin
                ss_cnt++;
                if (ss_first == 0) ss_first = k;
                ss_last = k;
            end
            if (m_ss === 1'b1 && (m_sck !== 1'b0 || m_mosi !== 1'b0)) viol++;
            if (m_done === 1'b1) begin done_cnt++; done_at = k; rx_at_done = m_rx; end
            if (m_sck === 1'b1 && prev_sck === 1'b0) begin
                got = {got[14:0], m_mosi};
                if (nrise == 0) first_rise = k;
                else if (nrise % 8 != 0 && k - last_rise != 2 * d) per_err++;
                last_rise = k;
                nrise++;
            end
            if (m_sck === 1'b1 && prev_sck === 1'b1 && m_mosi !== prev_mosi) viol++;
            exp_busy = (k <= 36 * d) ? 1'b1 : 1'b0;
            if (m_busy !== exp_busy) busy_err++;
            if (m_ss === 1'b0 && (k == 1 || (prev_sck === 1'b1 && m_sck === 1'b0)) && nrise < 16)
                miso = slave_word[15 - nrise];
            prev_sck = m_sck; prev_mosi = m_mosi;
        end
        total++; if (got !== {exp_b0, exp_b1}) begin bad++; $display("FAIL %s mosi_bytes got %h want %h", name, got, {exp_b0, exp_b1}); end
        total++; if (nrise != 16) begin bad++; $display("FAIL %s sck_rises got %0d want 16", name, nrise); end
        total++; if (ss_first != 1) begin bad++; $display("FAIL %s ss_fall_cycle got %0d want 1", name, ss_first); end
        total++; if (ss_cnt != 35 * d) begin bad++; $display("FAIL %s ss_low_cycles got %0d want %0d", name, ss_cnt, 35 * d); end
        total++; if (ss_last != 35 * d) begin bad++; $display("FAIL %s ss_last_low got %0d want %0d", name, ss_last, 35 * d); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL %s done_count got %0d want 1", name, done_cnt); end
        total++; if (done_at != 35 * d + 1) begin bad++; $display("FAIL %s done_cycle got %0d want %0d", name, done_at, 35 * d + 1); end
        total++; if (first_rise != 2 * d + 1) begin bad++; $display("FAIL %s first_rise got %0d want %0d", name, first_rise, 2 * d + 1); end
        total++; if (per_err != 0) begin bad++; $display("FAIL %s sck_period_errors got %0d want 0", name, per_err); end
        total++; if (viol != 0) begin bad++; $display("FAIL %s pin_rule_violations got %0d want 0", name, viol); end
        total++; if (busy_err != 0) begin bad++; $display("FAIL %s busy_errors got %0d want 0", name, busy_err); end
        total++; if (rx_at_done !== exp_rx) begin bad++; $display("FAIL %s rx_at_done got %h want %h", name, rx_at_done, exp_rx); end
        total++; if (m_rx !== exp_rx) begin bad++; $display("FAIL %s rx_after got %h want %h", name, m_rx, exp_rx); end
    endtask

    task automatic test_basic();
        test_frame("basic_2a5", 1'b0, 4, 10'h2A5, 4'h3, 8'h5C, 8'h81, 1'b0);
    endtask

    task automatic test_latch();
        test_frame("latch_2a5", 1'b0, 4, 10'h2A5, 4'h3, 8'h00, 8'h00, 1'b1);
    endtask

    task automatic test_miso();
        test_frame("miso_ffff", 1'b0, 4, 10'h155, 4'hA, 8'hFF, 8'hFF, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++)
            test_frame("random", 1'b0, 4, 10'($urandom), 4'($urandom),
                       8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic test_div2();
        test_frame("div2_3ff", 1'b1, 2, 10'h3FF, 4'hF, 8'($urandom), 8'($urandom), 1'b0);
    endtask

    // start held high for two frame lengths: exactly one frame, next one
    // accepted on the first IDLE cycle
    task automatic test_back_to_back();
        int d, falls, fall2, done_cnt, done_at;
        logic prev_ss;
        d = 4; falls = 0; fall2 = 0; done_cnt = 0; done_at = 0; prev_ss = 1'b1;
        sel = 1'b0;
        @(negedge clk);
        smp_in = 10'h0F0; ch_in = 4'h1; start4 = 1'b1;
        for (int k = 1; k <= 72 * d + 2; k++) begin
            @(negedge clk);
            if (k == 36 * d + 3) start4 = 1'b0;
            if (prev_ss === 1'b1 && m_ss === 1'b0) begin
                falls++;
                if (falls == 2) fall2 = k;
            end
            if (m_done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done_at = k;
            end
            if (k == 36 * d + 1) begin
                total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_first_frame got %0d want 1", done_cnt); end
            end
            prev_ss = m_ss;
        end
        total++; if (falls != 2) begin bad++; $display("FAIL b2b_frames got %0d want 2", falls); end
        total++; if (fall2 != 36 * d + 2) begin bad++; $display("FAIL b2b_second_start got %0d want %0d", fall2, 36 * d + 2); end
        total++; if (done_at != 35 * d + 1) begin bad++; $display("FAIL b2b_done_cycle got %0d want %0d", done_at, 35 * d + 1); end
        total++; if (done_cnt != 2) begin bad++; $display("FAIL b2b_done_total got %0d want 2", done_cnt); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got %b want 0", m_busy); end
    endtask

    // reset in the middle of byte1 aborts the frame immediately
    task automatic test_reset_mid_frame();
        int d, done_seen;
        logic [3:0] pins;
        d = 4; done_seen = 0;
        sel = 1'b0;
        @(negedge clk);
        smp_in = 10'h2A5; ch_in = 4'h3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (25 * d - 1) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        pins = {bus4.spi_ss, bus4.spi_sck, bus4.busy, bus4.spi_mosi};
        total++; if (pins !== 4'b1000) begin bad++; $display("FAIL rst_async_pins got %b want 1000", pins); end
        start4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (m_done === 1'b1) done_seen++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if ({m_ss, m_busy} !== 2'b01) begin bad++; $display("FAIL rst_release_accept got %b want 01", {m_ss, m_busy}); end
        start4 = 1'b0;
        for (int k = 2; k <= 36 * d + 1; k++) begin
            @(negedge clk);
            if (m_done === 1'b1) done_seen++;
        end
        total++; if (done_seen != 1) begin bad++; $display("FAIL rst_done_count got %0d want 1", done_seen); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL rst_frame_idle got %b want 0", m_busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_latch();
        test_miso();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_div2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_spi_master.md
ADC_SAMPLE_SPI_MASTER -- requirements
Module: adc_sample_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCK half-period; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: request to send one sample frame.
REQ-005 SHALL have port sample, input, 10: ADC sample value.
REQ-006 SHALL have port channel, input, 4: channel the sample came from.
REQ-007 SHALL have port busy, output, 1: high from accepted start until return to IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse at frame end.
REQ-009 SHALL have ports spi_ss (output, 1, active-low), spi_sck (output, 1), spi_mosi (output, 1), spi_miso (input, 1).
REQ-010 SHALL have port rx_data, output, 16: MISO bytes captured in the last frame, {byte1, byte0}.

Function
REQ-011 SHALL implement SPI mode 0, MSB first: MOSI changes only while SCK low; slave samples on SCK rising edge.
REQ-012 SHALL send byte0 = sample[7:0], then byte1 = {channel, 2'b00, sample[9:8]}.
REQ-013 SHALL use FSM IDLE -> SETUP -> BYTE0 -> GAP -> BYTE1 -> HOLD -> RECOVER -> IDLE.
REQ-014 SHALL accept start only in IDLE; start in any other state ignored, no queuing.
REQ-015 SHALL latch sample and channel at the accepting edge; later input changes do not affect the frame.
REQ-016 SHALL drive spi_ss low from cycle 1 after acceptance; SETUP, GAP, HOLD each last CLK_DIV cycles with SCK low.
REQ-017 SHALL spend 2*CLK_DIV cycles per bit (CLK_DIV low, CLK_DIV high); MOSI presents bit on entry to low half.
REQ-018 SHALL keep spi_ss low for exactly 35*CLK_DIV cycles; done pulses at cycle 35*CLK_DIV+1, the same cycle spi_ss returns high.
REQ-019 SHALL hold spi_ss high for CLK_DIV cycles in RECOVER before IDLE; busy deasserts entering IDLE.
REQ-020 SHALL force spi_mosi low and spi_sck low whenever spi_ss is high.
REQ-021 SHALL accept start on the first IDLE cycle after RECOVER (back-to-back frames).

Reset
REQ-022 SHALL, on rst assertion, immediately (asynchronously) force state IDLE, spi_ss=1, spi_sck=0, spi_mosi=0, busy=0, done=0, rx_data=0.
REQ-023 SHALL abort any in-progress frame on reset with no done pulse; start sampled high on the first edge after rst release is accepted.

Configuration
REQ-024 SHALL, with macro ADC_SPI_MISO_CAPTURE_EN defined, sample spi_miso on each SCK rising edge and update rx_data at the done cycle.
REQ-025 SHALL, without ADC_SPI_MISO_CAPTURE_EN, ignore spi_miso and tie rx_data to 16'h0000; all other timing identical.

Structure
REQ-026 SHALL place FSM state enumeration, frame length constant (16 bits), byte1 field positions (channel [7:4], sample MSBs [1:0]) in shared package adc_spi_pkg.
REQ-027 SHALL use one sub-module spi_sck_gen: CLK_DIV half-period counter giving sck level plus rise/fall strobes, enabled only in BYTE0/BYTE1.

Verification
REQ-028 SHALL cover: CLK_DIV=4, start with sample=10'h2A5, channel=4'h3 -> MOSI bytes 8'hA5 then 8'h32; spi_ss low 140 cycles; done at cycle 141.
REQ-029 SHALL cover: start pulsed every cycle during a frame -> exactly one frame; next frame begins on the first IDLE cycle.
REQ-030 SHALL cover: sample changed to 10'h000 one cycle after acceptance -> frame still carries the latched 10'h2A5.
REQ-031 SHALL cover: rst asserted mid-BYTE1 -> spi_ss=1, spi_sck=0, busy=0 without waiting for a clock edge; no done pulse.
REQ-032 SHALL cover, with ADC_SPI_MISO_CAPTURE_EN: slave returns 8'hFF, 8'hFF -> rx_data=16'hFFFF at done; without the macro -> rx_data stays 16'h0000.
REQ-033 SHALL cover: CLK_DIV=2, sample=10'h3FF, channel=4'hF -> bytes 8'hFF, 8'hF3; spi_ss low 70 cycles; SCK period 4 cycles.
